// File: rtl/gcd_pkg.sv
// Constants shared between the GCD datapath and its controller.
package gcd_pkg;
   localparam int WIDTH_DEF = 8;
   localparam int CNT_W_DEF = 8;

   // Mux select encodings driven by the controller on x_sel / y_sel
   localparam logic SEL_IN  = 1'b0;
   localparam logic SEL_SUB = 1'b1;
endpackage

// File: rtl/gcd_datapath_if.sv
// Controller <-> datapath strobe/status bundle; the controller is the master.
interface gcd_datapath_if;
   logic x_sel;
   logic x_ld;
   logic y_sel;
   logic y_ld;
   logic d_ld;
   logic x_neq_y;
   logic x_lt_y;

   modport master (output x_sel, x_ld, y_sel, y_ld, d_ld,
                   input  x_neq_y, x_lt_y);
   modport slave  (input  x_sel, x_ld, y_sel, y_ld, d_ld,
                   output x_neq_y, x_lt_y);
endinterface

// File: rtl/gcd_subcmp.sv
// Combinational subtract/compare unit: both wrapping differences plus != and unsigned <.
module gcd_subcmp
   import gcd_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] a_minus_b_o,
   output logic [WIDTH-1:0] b_minus_a_o,
   output logic             neq_o,
   output logic             lt_o
);
   assign a_minus_b_o = a_i - b_i;
   assign b_minus_a_o = b_i - a_i;
   assign neq_o       = (a_i != b_i);
   assign lt_o        = (a_i < b_i);
endmodule

// File: rtl/gcd_datapath.sv
// GCD datapath: X/Y/D registers, subtract-and-swap muxing, saturating step counter.
// Status is combinational from X/Y only, so it reflects a load one cycle after its strobe.
module gcd_datapath
   import gcd_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [WIDTH-1:0]   x_i,
   input  logic [WIDTH-1:0]   y_i,
   gcd_datapath_if.slave      ctrl,
   output logic [WIDTH-1:0]   d_o,
   output logic               d_valid,
   output logic [CNT_W-1:0]   iter_cnt
);
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             d_valid_q, d_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH-1:0] x_minus_y, y_minus_x;
   logic             opnd_load, sub_step;

   gcd_subcmp #(.WIDTH(WIDTH)) u_subcmp (
      .a_i         (x_q),
      .b_i         (y_q),
      .a_minus_b_o (x_minus_y),
      .b_minus_a_o (y_minus_x),
      .neq_o       (ctrl.x_neq_y),
      .lt_o        (ctrl.x_lt_y)
   );

   assign opnd_load = (ctrl.x_ld && ctrl.x_sel == SEL_IN)  || (ctrl.y_ld && ctrl.y_sel == SEL_IN);
   assign sub_step  = (ctrl.x_ld && ctrl.x_sel == SEL_SUB) || (ctrl.y_ld && ctrl.y_sel == SEL_SUB);

   always_comb begin
      x_d       = x_q;
      y_d       = y_q;
      d_d       = d_q;
      d_valid_d = d_valid_q;
      cnt_d     = cnt_q;

      if (ctrl.x_ld) x_d = (ctrl.x_sel == SEL_SUB) ? x_minus_y : x_i;
      if (ctrl.y_ld) y_d = (ctrl.y_sel == SEL_SUB) ? y_minus_x : y_i;

      // A result capture in the same cycle as a new operand load keeps d_valid set
      if (ctrl.d_ld) begin
         d_d       = x_q;
         d_valid_d = 1'b1;
      end else if (opnd_load) begin
         d_valid_d = 1'b0;
      end

      if (opnd_load)
         cnt_d = '0;
      else if (sub_step && cnt_q != {CNT_W{1'b1}})
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         x_q       <= '0;
         y_q       <= '0;
         d_q       <= '0;
         d_valid_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         x_q       <= x_d;
         y_q       <= y_d;
         d_q       <= d_d;
         d_valid_q <= d_valid_d;
         cnt_q     <= cnt_d;
      end
   end

   assign d_o      = d_q;
   assign d_valid  = d_valid_q;
   assign iter_cnt = cnt_q;
endmodule

// File: tb/tb_gcd_datapath.sv
// Bench for gcd_datapath (CNT_W = 4 so saturation is reachable); reference model tracks X/Y/D/valid/count.
module tb_gcd_datapath;
   import gcd_pkg::*;

   localparam int W    = 8;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;
   localparam int MOD  = 1 << W;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  x_i = '0;
   logic [W-1:0]  y_i = '0;
   logic [W-1:0]  d_o;
   logic          d_valid;
   logic [CW-1:0] iter_cnt;

   gcd_datapath_if ctrl_if ();

   gcd_datapath #(.WIDTH(W), .CNT_W(CW)) dut (
      .CLK      (clk),
      .RESET    (rst),
      .x_i      (x_i),
      .y_i      (y_i),
      .ctrl     (ctrl_if),
      .d_o      (d_o),
      .d_valid  (d_valid),
      .iter_cnt (iter_cnt)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference state
   int mx = 0, my = 0, md = 0, mv = 0, mc = 0;

   task automatic check(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   function automatic int gcd_ref(input int a, input int b);
      int t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Subtractive Euclid takes (sum of Euclidean quotients) - 1 subtract steps
   function automatic int steps_ref(input int a, input int b);
      int s, t;
      s = 0;
      while (b != 0) begin
         s += a / b;
         t = a % b;
         a = b;
         b = t;
      end
      return s - 1;
   endfunction

   task automatic step(input logic r, input logic xl, input logic xs, input logic yl,
                       input logic ys, input logic dl, input int xv, input int yv,
                       input string tag);
      int ox, oy;
      bit load, sub;
      rst = r;
      ctrl_if.x_ld = xl; ctrl_if.x_sel = xs;
      ctrl_if.y_ld = yl; ctrl_if.y_sel = ys;
      ctrl_if.d_ld = dl;
      x_i = W'(xv);
      y_i = W'(yv);

      if (r) begin
         mx = 0; my = 0; md = 0; mv = 0; mc = 0;
      end else begin
         ox = mx; oy = my;
         load = (xl && !xs) || (yl && !ys);
         sub  = (xl && xs) || (yl && ys);
         if (xl) mx = xs ? (ox - oy + MOD) % MOD : xv;
         if (yl) my = ys ? (oy - ox + MOD) % MOD : yv;
         if (dl) begin md = ox; mv = 1; end
         else if (load) mv = 0;
         if (load) mc = 0;
         else if (sub && mc < CMAX) mc++;
      end

      @(posedge clk);
      #1;
      check({tag, ".neq"},   int'(ctrl_if.x_neq_y), int'(mx != my));
      check({tag, ".lt"},    int'(ctrl_if.x_lt_y),  int'(mx < my));
      check({tag, ".d"},     int'(d_o),             md);
      check({tag, ".valid"}, int'(d_valid),         mv);
      check({tag, ".cnt"},   int'(iter_cnt),        mc);
   endtask

   task automatic idle(input string tag);
      step(1'b0, 1'b0, SEL_IN, 1'b0, SEL_IN, 1'b0, 0, 0, tag);
   endtask

   task automatic load(input int a, input int b, input string tag);
      step(1'b0, 1'b1, SEL_IN, 1'b1, SEL_IN, 1'b0, a, b, tag);
   endtask

   task automatic xsub(input string tag);
      step(1'b0, 1'b1, SEL_SUB, 1'b0, SEL_IN, 1'b0, 0, 0, tag);
   endtask

   task automatic ysub(input string tag);
      step(1'b0, 1'b0, SEL_IN, 1'b1, SEL_SUB, 1'b0, 0, 0, tag);
   endtask

   task automatic dload(input string tag);
      step(1'b0, 1'b0, SEL_IN, 1'b0, SEL_IN, 1'b1, 0, 0, tag);
   endtask

   // Acts as the controller: subtract until equal, capture, then check against Euclid
   task automatic run_gcd(input int a, input int b, input string tag);
      int guard;
      load(a, b, {tag, ".load"});
      guard = 0;
      while (mx != my && guard < 400) begin
         if (mx > my) xsub({tag, ".xsub"});
         else         ysub({tag, ".ysub"});
         guard++;
      end
      if (guard >= 400) begin
         n_chk++; n_fail++;
         $display("FAIL %s.timeout: got %0d steps, expected termination", tag, guard);
      end
      dload({tag, ".dld"});
      check({tag, ".gcd"},   int'(d_o),      gcd_ref(a, b));
      check({tag, ".steps"}, int'(iter_cnt),
            (steps_ref(a, b) > CMAX) ? CMAX : steps_ref(a, b));
   endtask

   initial begin
      ctrl_if.x_ld = 1'b0; ctrl_if.x_sel = SEL_IN;
      ctrl_if.y_ld = 1'b0; ctrl_if.y_sel = SEL_IN;
      ctrl_if.d_ld = 1'b0;

      // Reset state, with strobes asserted to show reset dominates
      step(1'b1, 1'b1, SEL_IN, 1'b1, SEL_IN, 1'b1, 7, 3, "reset");
      check("reset.status_neq", int'(ctrl_if.x_neq_y), 0);
      check("reset.status_lt",  int'(ctrl_if.x_lt_y),  0);
      idle("idle0");

      // GCD(12,18)
      load(12, 18, "g12.load");
      check("g12.lt_after_load", int'(ctrl_if.x_lt_y), 1);
      ysub("g12.ysub");
      xsub("g12.xsub");
      check("g12.equal", int'(ctrl_if.x_neq_y), 0);
      dload("g12.dld");
      check("g12.d",     int'(d_o),      6);
      check("g12.valid", int'(d_valid),  1);
      check("g12.cnt",   int'(iter_cnt), 2);

      // GCD(35,14): x_lt_y only while X=7, Y=14
      load(35, 14, "g35.load");
      xsub("g35.x21");
      check("g35.lt_21", int'(ctrl_if.x_lt_y), 0);
      xsub("g35.x7");
      check("g35.lt_7", int'(ctrl_if.x_lt_y), 1);
      ysub("g35.y7");
      check("g35.lt_eq", int'(ctrl_if.x_lt_y), 0);
      dload("g35.dld");
      check("g35.d",   int'(d_o),      7);
      check("g35.cnt", int'(iter_cnt), 3);

      // Simultaneous subtracts use pre-edge values and count once
      load(9, 4, "sim.load");
      step(1'b0, 1'b1, SEL_SUB, 1'b1, SEL_SUB, 1'b0, 0, 0, "sim.both");
      check("sim.x5", mx, 5);
      check("sim.cnt", int'(iter_cnt), 1);
      check("sim.lt", int'(ctrl_if.x_lt_y), 1);
      // d_ld together with x_ld captures old X (5)
      step(1'b0, 1'b1, SEL_SUB, 1'b0, SEL_IN, 1'b1, 0, 0, "sim.dx");
      check("sim.d_oldx", int'(d_o), 5);

      // New operands after a result: valid drops, count clears, D holds
      load(20, 8, "new.load");
      check("new.valid", int'(d_valid),         0);
      check("new.cnt",   int'(iter_cnt),        0);
      check("new.d",     int'(d_o),             5);
      check("new.neq",   int'(ctrl_if.x_neq_y), 1);
      check("new.lt",    int'(ctrl_if.x_lt_y),  0);

      // Operand load with d_ld in the same cycle: d_ld wins for valid
      step(1'b0, 1'b1, SEL_IN, 1'b1, SEL_IN, 1'b1, 6, 6, "ldd.both");
      check("ldd.valid", int'(d_valid), 1);

      // Saturation
      run_gcd(255, 1, "sat");
      check("sat.cnt15", int'(iter_cnt), 15);
      check("sat.d1",    int'(d_o),      1);

      // Reset mid-operation with x_ld also high
      load(35, 14, "rmid.load");
      xsub("rmid.xsub");
      step(1'b1, 1'b1, SEL_IN, 1'b0, SEL_IN, 1'b0, 99, 0, "rmid.rst");
      check("rmid.d",     int'(d_o),             0);
      check("rmid.valid", int'(d_valid),         0);
      check("rmid.cnt",   int'(iter_cnt),        0);
      check("rmid.neq",   int'(ctrl_if.x_neq_y), 0);
      idle("rmid.idle");

      // Random operand pairs
      for (int i = 0; i < 24; i++) begin
         run_gcd(int'($urandom_range(1, MOD - 1)), int'($urandom_range(1, MOD - 1)), "rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
